wb_deserializer: RTL and testbench
==================================

WB_DESERIALIZER -- requirements
Module: wb_deserializer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clk_i cycles per serial bit (legal range 4..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO word count (power of two).
REQ-003 The block SHALL have port clk_i  input  1  single clock, rising edge, used for both the serial line and Wishbone.
REQ-004 The block SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port data_i  input  1  serial line, idle high, asynchronous to clk_i.
REQ-006 The block SHALL have port rx_valid_o  output  1  high while the FIFO is non-empty.
REQ-007 The block SHALL have Wishbone ports CYC_I 1, STB_I 1, WE_I 1, ADR_I 32, DAT_I 32 as inputs and ACK_O 1, ERR_O 1, DAT_O 32 as outputs.

Function
REQ-008 data_i SHALL pass through a 2-flop synchronizer (reset value 1) before use.
REQ-009 Frame format SHALL be: start bit 0, then 27 data bits MSB first, then stop bit 1; data bits map to {k2,byte2,k1,byte1,k0,byte0}, where k=1 marks a K-code.
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-011 IDLE->START SHALL occur on a synchronized falling edge.
REQ-012 START SHALL resample at CLKS_PER_BIT/2 cycles; if low, go to DATA, else return to IDLE (glitch reject).
REQ-013 DATA SHALL sample every CLKS_PER_BIT cycles into a 27-bit shift register; after the 27th sample, go to STOP.
REQ-014 STOP SHALL sample once after CLKS_PER_BIT cycles, then return to IDLE.
REQ-015 A stop bit of 1 SHALL push {5'b0, word[26:0]} into the FIFO on the cycle after the stop sample.
REQ-016 A stop bit of 0 SHALL discard the word and set sticky frame_err.
REQ-017 A push while the FIFO is full SHALL drop the new word and set sticky overflow; FIFO contents SHALL remain unchanged.
REQ-018 A simultaneous push and pop while full SHALL succeed with no overflow; a simultaneous push and pop while empty SHALL return DAT_O=0 and leave the pushed word stored.
REQ-019 Register map, decoded on ADR_I[1:0], SHALL be: 0 ADR_DATA (R), 1 ADR_STATUS (R), 2 ADR_CTRL (W), 3 invalid.
REQ-020 ACK_O SHALL be combinational, CYC_I & STB_I, for legal accesses.
REQ-021 ERR_O SHALL be CYC_I & STB_I for address 3, for a write to DATA/STATUS, or for a read of CTRL; ACK_O SHALL be 0 whenever ERR_O is 1.
REQ-022 An acknowledged DATA read SHALL present the FIFO head on DAT_O and pop it on that clock edge; a read while empty SHALL return 0 and not pop.
REQ-023 STATUS SHALL read as: [2:0] count (saturating at FIFO_DEPTH; wider count fields for larger depth), [3] empty, [4] full, [5] overflow, [6] frame_err, [7] busy (FSM not IDLE); other bits 0.
REQ-024 A CTRL write with DAT_I[0]=1 SHALL clear overflow and frame_err; a flag-set event in the same cycle SHALL win.
REQ-025 A CTRL write with DAT_I[1]=1 SHALL flush the FIFO; a flush in the same cycle as a push SHALL win (word lost, no overflow).
REQ-026 DAT_O SHALL be 0 when not acknowledging a read.

Reset
REQ-027 Asserting rst_ni low SHALL asynchronously force: FSM IDLE, bit/sample counters 0, shift register 0, FIFO pointers 0, overflow=0, frame_err=0, rx_valid_o=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no push; reception SHALL resume on the next falling edge after release.

Structure
REQ-029 Package WBDeserializer SHALL hold NUM_REGS, ADR_DATA, ADR_STATUS, ADR_CTRL, FRAME_BITS=27, the STATUS bit indices, and the FSM state typedef.
REQ-030 Sub-module serializer_out SHALL contain the synchronizer, FSM and shift register, and output word, word_valid pulse and frame_err pulse; FIFO, flags and Wishbone decode SHALL live in the top.

Verification
REQ-031 Frame 0x69478FF (k2=1, 0xA5, k1=0, 0x3C, k0=0, 0xFF) with CLKS_PER_BIT=4 -> rx_valid_o=1; DATA read returns 0x069478FF; STATUS then reads 0x08.
REQ-032 A low glitch of 1 cycle on idle data_i -> no push; busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-033 A frame with stop bit 0 -> no push; STATUS[6]=1; CTRL write 0x1 -> STATUS[6]=0.
REQ-034 5 frames sent with no reads -> STATUS=0x34 (count 4, full, overflow); 4 reads return the first 4 words in order, then empty.
REQ-035 rst_ni pulsed low mid-DATA, then a full frame 0x0000123 sent -> exactly one word 0x00000123 read back.
REQ-036 Read of ADR_I=3, and a write to ADR_DATA -> ERR_O=1, ACK_O=0, FIFO unchanged.

Source files
------------

// File: rtl/wb_deserializer_pkg.sv
// Shared constants and types for the Wishbone serial-frame deserializer.
// Holds the register map, frame length, STATUS bit positions, CTRL bit
// positions and the receiver FSM state type.
package WBDeserializer;

  localparam int unsigned NUM_REGS   = 4;
  localparam logic [1:0]  ADR_DATA   = 2'd0;
  localparam logic [1:0]  ADR_STATUS = 2'd1;
  localparam logic [1:0]  ADR_CTRL   = 2'd2;

  localparam int unsigned FRAME_BITS = 27;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned BAUD_CNT_W = 8;

  // STATUS layout for the default depth; count lives in [2:0]
  localparam int unsigned STAT_CNT_LSB = 0;
  localparam int unsigned STAT_EMPTY   = 3;
  localparam int unsigned STAT_FULL    = 4;
  localparam int unsigned STAT_OVF     = 5;
  localparam int unsigned STAT_FERR    = 6;
  localparam int unsigned STAT_BUSY    = 7;

  localparam int unsigned CTRL_CLR   = 0;
  localparam int unsigned CTRL_FLUSH = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/wb_deserializer_serializer_out.sv
// Serial receiver: synchronizes data_i, detects the start bit, shifts in
// 27 data bits MSB first and checks the stop bit.
// Ports: clk_i/rst_ni clock and async active-low reset, data_i serial line,
// word_o received word, word_valid_o one-cycle pulse on good stop bit,
// frame_err_o one-cycle pulse on bad stop bit, busy_o FSM not idle.
module serializer_out
  import WBDeserializer::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_i,
  output logic [FRAME_BITS-1:0] word_o,
  output logic                  word_valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);

  rx_state_e               state_q, state_d;
  logic [1:0]              sync_q;
  logic                    prev_q;
  logic [BAUD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]    bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    word_valid_q, word_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    busy_q;
  logic                    line_c, fall_c;

  assign line_c = sync_q[1];
  assign fall_c = prev_q & ~line_c;

  // Two-flop synchronizer plus edge-detect history, all idle-high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], data_i};
      prev_q <= line_c;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; START resamples mid-bit to reject glitches
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fall_c) state_d = ST_START;
      ST_START: if (cnt_q == HALF_LAST) state_d = line_c ? ST_IDLE : ST_DATA;
      ST_DATA:  if (cnt_q == BIT_LAST && bit_q == LAST_BIT) state_d = ST_STOP;
      ST_STOP:  if (cnt_q == BIT_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counter, shift and pulse next values per state
  always_comb begin
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      ST_START: cnt_d = (cnt_q == HALF_LAST) ? '0 : cnt_q + BAUD_CNT_W'(1);
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[FRAME_BITS-2:0], line_c};
          bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + BIT_CNT_W'(1);
        end else begin
          cnt_d = cnt_q + BAUD_CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          word_valid_d = line_c;
          frame_err_d  = ~line_c;
        end else begin
          cnt_d = cnt_q + BAUD_CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign word_o       = shift_q;
  assign word_valid_o = word_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/wb_deserializer.sv
// Serial frame receiver with a receive FIFO behind a Wishbone slave.
// Ports: clk_i/rst_ni clock and async active-low reset, data_i serial line,
// rx_valid_o FIFO non-empty, CYC_I/STB_I/WE_I/ADR_I/DAT_I Wishbone request,
// ACK_O/ERR_O single-cycle combinational response, DAT_O read data.
module wb_deserializer
  import WBDeserializer::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_i,
  output logic        rx_valid_o,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O
);

  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STAT_CNT_W = (CNT_W > 3) ? CNT_W : 3;
  localparam int unsigned FLAG_OFS   = STAT_CNT_W - 3;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(FIFO_DEPTH - 1);

  logic [FRAME_BITS-1:0] rx_word;
  logic                  rx_push, rx_ferr, rx_busy;

  serializer_out #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .word_o       (rx_word),
    .word_valid_o (rx_push),
    .frame_err_o  (rx_ferr),
    .busy_o       (rx_busy)
  );

  logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d, ferr_q, ferr_d, rx_valid_q;
  logic                  sel_c, legal_c, rd_c, ctrl_c, flush_c, clr_c;
  logic                  empty_c, full_c, pop_c, push_c, push_ok_c, ovf_set_c;
  logic [31:0]           status_c;
  logic                  unused_bits;

  assign unused_bits = ^{ADR_I[31:2], DAT_I[31:2]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_END) ? '0 : p + PTR_W'(1);
  endfunction

  // Register decode: DATA/STATUS read-only, CTRL write-only, address 3 invalid
  always_comb begin
    legal_c = 1'b0;
    unique case (ADR_I[1:0])
      ADR_DATA, ADR_STATUS: legal_c = ~WE_I;
      ADR_CTRL:             legal_c = WE_I;
      default:              legal_c = 1'b0;
    endcase
  end

  assign sel_c   = CYC_I & STB_I;
  assign ACK_O   = sel_c & legal_c;
  assign ERR_O   = sel_c & ~legal_c;
  assign rd_c    = ACK_O & ~WE_I;
  assign ctrl_c  = ACK_O & WE_I & (ADR_I[1:0] == ADR_CTRL);
  assign flush_c = ctrl_c & DAT_I[CTRL_FLUSH];
  assign clr_c   = ctrl_c & DAT_I[CTRL_CLR];

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == DEPTH_C);
  assign pop_c     = rd_c & (ADR_I[1:0] == ADR_DATA) & ~empty_c;
  // Flush beats a same-cycle push; a pop frees a slot for a push when full
  assign push_c    = rx_push & ~flush_c;
  assign push_ok_c = push_c & (~full_c | pop_c);
  assign ovf_set_c = push_c & full_c & ~pop_c;

  // FIFO pointer / occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)     rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a clear wins
  assign ovf_d  = ovf_set_c | (ovf_q & ~clr_c);
  assign ferr_d = rx_ferr | (ferr_q & ~clr_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      rx_valid_q <= (count_d != '0);
    end
  end

  // Storage is not reset; occupancy tracking guards every read
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= rx_word;
  end

  always_comb begin
    status_c = '0;
    status_c[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(count_q);
    status_c[STAT_EMPTY + FLAG_OFS]      = empty_c;
    status_c[STAT_FULL + FLAG_OFS]       = full_c;
    status_c[STAT_OVF + FLAG_OFS]        = ovf_q;
    status_c[STAT_FERR + FLAG_OFS]       = ferr_q;
    status_c[STAT_BUSY + FLAG_OFS]       = rx_busy;
  end

  // Read data is zero unless a read is being acknowledged
  always_comb begin
    DAT_O = '0;
    if (rd_c) begin
      if (ADR_I[1:0] == ADR_DATA) begin
        if (!empty_c) DAT_O = 32'(mem_q[rd_ptr_q]);
      end else begin
        DAT_O = status_c;
      end
    end
  end

  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_wb_deserializer.sv
// Randomized scoreboard bench for wb_deserializer: a queue-based FIFO/flag
// model predicts every Wishbone response; a negedge monitor checks them.
module tb_wb_deserializer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        data_i;
  logic        rx_valid_o;
  logic        CYC_I, STB_I, WE_I;
  logic [31:0] ADR_I, DAT_I;
  logic        ACK_O, ERR_O;
  logic [31:0] DAT_O;

  always #5 clk = ~clk;

  wb_deserializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .rx_valid_o (rx_valid_o),
    .CYC_I      (CYC_I),
    .STB_I      (STB_I),
    .WE_I       (WE_I),
    .ADR_I      (ADR_I),
    .DAT_I      (DAT_I),
    .ACK_O      (ACK_O),
    .ERR_O      (ERR_O),
    .DAT_O      (DAT_O)
  );

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [26:0] model_q[$];
  bit          m_ovf, m_ferr;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, want);
    end
  endtask

  // Monitor: every bus access consumes one expected response
  exp_t mon_e;
  always @(negedge clk) begin
    if (CYC_I && STB_I) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access: got adr=%0d with no expectation queued", ADR_I[1:0]);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.tag, "_ack"}, 32'(ACK_O), 32'(mon_e.ack));
        check({mon_e.tag, "_err"}, 32'(ERR_O), 32'(mon_e.err));
        check({mon_e.tag, "_dat"}, DAT_O, mon_e.dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                           input exp_t e);
    exp_q.push_back(e);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = we;
    ADR_I = {30'($urandom), adr};
    DAT_I = wdat;
    tick();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    ADR_I = '0;
    DAT_I = '0;
  endtask

  function automatic logic [31:0] model_status(input bit busy);
    int n = model_q.size();
    return 32'(n) | ((n == 0) ? 32'h08 : 32'h0) | ((n == DEPTH) ? 32'h10 : 32'h0) |
           (m_ovf ? 32'h20 : 32'h0) | (m_ferr ? 32'h40 : 32'h0) | (busy ? 32'h80 : 32'h0);
  endfunction

  task automatic read_data(input string tag);
    exp_t e;
    e.ack = 1'b1; e.err = 1'b0; e.tag = tag;
    e.dat = (model_q.size() == 0) ? 32'h0 : 32'(model_q.pop_front());
    wb_access(1'b0, 2'd0, 32'($urandom), e);
  endtask

  task automatic read_status(input string tag, input bit busy);
    exp_t e;
    e.ack = 1'b1; e.err = 1'b0; e.tag = tag; e.dat = model_status(busy);
    wb_access(1'b0, 2'd1, 32'($urandom), e);
  endtask

  task automatic write_ctrl(input string tag, input logic [1:0] v);
    exp_t e;
    e.ack = 1'b1; e.err = 1'b0; e.tag = tag; e.dat = 32'h0;
    if (v[0]) begin m_ovf = 1'b0; m_ferr = 1'b0; end
    if (v[1]) model_q.delete();
    wb_access(1'b1, 2'd2, {30'($urandom), v}, e);
  endtask

  task automatic bad_access(input string tag, input logic we, input logic [1:0] adr);
    exp_t e;
    e.ack = 1'b0; e.err = 1'b1; e.tag = tag; e.dat = 32'h0;
    wb_access(we, adr, 32'($urandom), e);
  endtask

  // mode: 0 plain, 1 STATUS read mid-frame, 2 DATA read on the push edge,
  // 3 flush on the push edge, 4 flag clear on the push/frame-error edge
  task automatic send_frame(input logic [26:0] w, input bit stop, input int mode);
    logic [28:0] bits = {1'b0, w, stop};
    for (int i = 28; i >= 0; i--) begin
      data_i = bits[i];
      for (int c = 0; c < CPB; c++) begin
        if (mode == 1 && i == 18 && c == 0) read_status("busy_probe", 1'b1);
        else tick();
      end
    end
    data_i = 1'b1;
    tick();
    case (mode)
      2:       read_data("rd_at_push");
      3:       write_ctrl("flush_at_push", 2'b10);
      4:       write_ctrl("clr_at_push", 2'b01);
      default: tick();
    endcase
    repeat (6) tick();
    if (!stop) m_ferr = 1'b1;
    else if (mode != 3) begin
      if (model_q.size() == DEPTH) m_ovf = 1'b1;
      else model_q.push_back(w);
    end
  endtask

  task automatic check_rx(input string tag);
    check(tag, 32'(rx_valid_o), 32'(model_q.size() != 0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; data_i = 1'b1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
    m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (3) tick();
    check_rx("reset_rx_valid");
    rst_ni = 1'b1;
    tick();
    read_status("reset_status", 1'b0);

    // Reference frame with a busy probe mid-frame
    send_frame(27'h69478FF, 1'b1, 1);
    check_rx("ref_rx_valid");
    read_data("ref_data");
    read_status("ref_status_empty", 1'b0);
    tick();
    check_rx("ref_rx_valid_after");

    // One-cycle glitch on an idle line
    data_i = 1'b0; tick(); data_i = 1'b1;
    repeat (CPB / 2 + 3) tick();
    read_status("glitch_status", 1'b0);

    // Bad stop bit, then clear
    send_frame(27'($urandom), 1'b0, 0);
    read_status("ferr_status", 1'b0);
    write_ctrl("ferr_clear", 2'b01);
    read_status("ferr_cleared", 1'b0);

    // Overflow: five frames, no reads
    for (int i = 0; i < 5; i++) send_frame(27'($urandom), 1'b1, 0);
    read_status("ovf_status", 1'b0);
    for (int i = 0; i < 4; i++) read_data("ovf_drain");
    read_data("ovf_empty_read");
    read_status("ovf_after_drain", 1'b0);
    write_ctrl("ovf_clear", 2'b01);

    // Push/pop on the same edge: empty then full
    send_frame(27'($urandom), 1'b1, 2);
    read_data("empty_pushpop_stored");
    for (int i = 0; i < 4; i++) send_frame(27'($urandom), 1'b1, 0);
    send_frame(27'($urandom), 1'b1, 2);
    read_status("full_pushpop_status", 1'b0);
    // Push into full with same-cycle clear: overflow set wins
    send_frame(27'($urandom), 1'b1, 4);
    read_status("ovf_set_wins", 1'b0);
    write_ctrl("flush_all", 2'b11);
    read_status("flushed", 1'b0);

    // Frame error with same-cycle clear, and flush racing a push
    send_frame(27'($urandom), 1'b0, 4);
    read_status("ferr_set_wins", 1'b0);
    send_frame(27'($urandom), 1'b1, 3);
    read_status("flush_beats_push", 1'b0);
    write_ctrl("clr2", 2'b01);

    // Illegal accesses leave the FIFO untouched
    send_frame(27'($urandom), 1'b1, 0);
    bad_access("err_adr3_rd", 1'b0, 2'd3);
    bad_access("err_adr3_wr", 1'b1, 2'd3);
    bad_access("err_wr_data", 1'b1, 2'd0);
    bad_access("err_wr_status", 1'b1, 2'd1);
    bad_access("err_rd_ctrl", 1'b0, 2'd2);
    read_status("err_status", 1'b0);
    read_data("err_data");

    // Reset in the middle of DATA, with flags and FIFO populated
    send_frame(27'($urandom), 1'b0, 0);
    send_frame(27'($urandom), 1'b1, 0);
    data_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 10; i++) begin
      data_i = 1'($urandom);
      repeat (CPB) tick();
    end
    rst_ni = 1'b0; data_i = 1'b1;
    model_q.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (2) tick();
    check_rx("midreset_rx_valid");
    rst_ni = 1'b1;
    repeat (3) tick();
    send_frame(27'h0000123, 1'b1, 0);
    read_data("post_reset_word");
    read_data("post_reset_empty");
    read_status("post_reset_status", 1'b0);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: send_frame(27'($urandom), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 4)));
        2:    read_data("rnd_data");
        3:    read_status("rnd_status", 1'b0);
        4:    write_ctrl("rnd_ctrl", 2'($urandom));
        default: bad_access("rnd_bad", 1'b0, 2'd3);
      endcase
      tick();
      check_rx("rnd_rx_valid");
    end

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
